// File: rtl/alu_bus_master.sv
// Bus-master sequencer for the ALU/multiplier slave: loads operands and opcode,
// starts the slave, polls opdone, collects the result, clears the slave, responds.
module alu_bus_master #(
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         POLL_LIMIT = 1024,
  parameter logic [3:0] MUL_OPCODE = 4'hD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_timeout,
  output logic        M_sel,
  output logic        M_wr,
  output logic [7:0]  M_addr,
  output logic [31:0] M_dout,
  input  logic [31:0] M_din
);

  localparam int CNT_W = $clog2(POLL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_LIMIT - 1);

  localparam logic [2:0] REG_A     = 3'd0;
  localparam logic [2:0] REG_B     = 3'd1;
  localparam logic [2:0] REG_OP    = 3'd2;
  localparam logic [2:0] REG_START = 3'd3;
  localparam logic [2:0] REG_DONE  = 3'd4;
  localparam logic [2:0] REG_CLR   = 3'd5;
  localparam logic [2:0] REG_RES1  = 3'd6;
  localparam logic [2:0] REG_RES2  = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_OP, S_WR_START, S_POLL,
    S_RD_LO, S_RD_HI, S_CLEAR, S_CLR_WAIT, S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        hi_q, hi_d;
  logic               to_q, to_d;
  logic [2:0]         bus_idx;
  logic               poll_done;
  logic               poll_last;
  logic               is_mul;

  assign poll_done = (M_din[1:0] == 2'b11);
  assign poll_last = (cnt_q == CNT_LAST);
  assign is_mul    = (op_q == MUL_OPCODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cmd_valid) state_d = S_WR_A;
      S_WR_A:     state_d = S_WR_B;
      S_WR_B:     state_d = S_WR_OP;
      S_WR_OP:    state_d = S_WR_START;
      S_WR_START: state_d = S_POLL;
      S_POLL: begin
        if (poll_done)      state_d = S_RD_LO;
        else if (poll_last) state_d = S_CLEAR;
      end
      S_RD_LO:    state_d = is_mul ? S_RD_HI : S_CLEAR;
      S_RD_HI:    state_d = S_CLEAR;
      S_CLEAR:    state_d = S_CLR_WAIT;
      S_CLR_WAIT: state_d = S_RESP;
      S_RESP:     if (rsp_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Job latch, poll counter and response capture.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    lo_d  = lo_q;
    hi_d  = hi_q;
    to_d  = to_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d  = cmd_a;
          b_d  = cmd_b;
          op_d = cmd_op;
          lo_d = '0;
          hi_d = '0;
          to_d = 1'b0;
        end
      end
      S_WR_START: cnt_d = '0;
      S_POLL: begin
        if (!poll_done) begin
          if (poll_last) to_d  = 1'b1;
          else           cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_LO: begin
        lo_d = M_din;
        if (!is_mul) hi_d = '0;
      end
      S_RD_HI: hi_d = M_din;
      default: ;
    endcase
  end

  // Bus signals are pure functions of state so they never depend on M_din.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    M_sel     = 1'b0;
    M_wr      = 1'b0;
    M_dout    = '0;
    bus_idx   = 3'd0;
    case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_WR_A: begin
        M_sel = 1'b1; M_wr = 1'b1; bus_idx = REG_A; M_dout = a_q;
      end
      S_WR_B: begin
        M_sel = 1'b1; M_wr = 1'b1; bus_idx = REG_B; M_dout = b_q;
      end
      S_WR_OP: begin
        M_sel = 1'b1; M_wr = 1'b1; bus_idx = REG_OP; M_dout = {28'b0, op_q};
      end
      S_WR_START: begin
        M_sel = 1'b1; M_wr = 1'b1; bus_idx = REG_START; M_dout = 32'h1;
      end
      S_POLL: begin
        M_sel = 1'b1; bus_idx = REG_DONE;
      end
      S_RD_LO: begin
        M_sel = 1'b1; bus_idx = REG_RES1;
      end
      S_RD_HI: begin
        M_sel = 1'b1; bus_idx = REG_RES2;
      end
      S_CLEAR: begin
        M_sel = 1'b1; M_wr = 1'b1; bus_idx = REG_CLR; M_dout = 32'h1;
      end
      S_CLR_WAIT: begin
        M_sel = 1'b1; bus_idx = REG_CLR;
      end
      S_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign M_addr      = M_sel ? (BASE_ADDR | {5'b0, bus_idx}) : 8'h00;
  assign rsp_lo      = lo_q;
  assign rsp_hi      = hi_q;
  assign rsp_timeout = to_q;

endmodule
